// File: rtl/graph_connectivity_sequencer.sv
// Weak-connectivity reachability engine: one symmetrised NxN adjacency matrix per
// transaction, one row scanned per cycle. Optional macro: GRAPH_SEQ_EARLY_EXIT_EN.
module graph_connectivity_sequencer #(
  parameter  int unsigned NODES  = 4,
  localparam int unsigned PASS_W = $clog2(NODES + 1)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NODES*NODES-1:0]   in_adj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_connected,
  output logic [NODES-1:0]         out_visited,
  output logic [PASS_W-1:0]        out_passes
);

  localparam int unsigned PTR_W = (NODES > 1) ? $clog2(NODES) : 1;

`ifdef GRAPH_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [NODES-1:0][NODES-1:0]   adj_q, adj_d;
  logic [NODES-1:0][NODES-1:0]   sym;
  logic [NODES-1:0]              visited_q, visited_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [PASS_W-1:0]             pass_q, pass_d;
  logic                          changed_q, changed_d;

  logic                          in_ready_d;
  logic                          out_valid_d;
  logic                          out_connected_d;
  logic [NODES-1:0]              out_visited_d;
  logic [PASS_W-1:0]             out_passes_d;

  logic [NODES-1:0]              nxt;
  logic                          chg;
  logic                          last_row;
  logic                          finish;

  // Edge i->j or j->i both count as an undirected edge
  always_comb begin
    sym = '0;
    for (int i = 0; i < int'(NODES); i++) begin
      for (int j = 0; j < int'(NODES); j++) begin
        sym[i][j] = in_adj[i*NODES + j] | in_adj[j*NODES + i];
      end
    end
  end

  // Row update for the currently scanned node
  always_comb begin
    nxt      = visited_q[ptr_q] ? (visited_q | adj_q[ptr_q]) : visited_q;
    chg      = changed_q | (nxt != visited_q);
    last_row = (ptr_q == PTR_W'(NODES - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      adj_q         <= '0;
      visited_q     <= '0;
      ptr_q         <= '0;
      pass_q        <= '0;
      changed_q     <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_connected <= 1'b0;
      out_visited   <= '0;
      out_passes    <= '0;
    end else begin
      state_q       <= state_d;
      adj_q         <= adj_d;
      visited_q     <= visited_d;
      ptr_q         <= ptr_d;
      pass_q        <= pass_d;
      changed_q     <= changed_d;
      in_ready      <= in_ready_d;
      out_valid     <= out_valid_d;
      out_connected <= out_connected_d;
      out_visited   <= out_visited_d;
      out_passes    <= out_passes_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    adj_d           = adj_q;
    visited_d       = visited_q;
    ptr_d           = ptr_q;
    pass_d          = pass_q;
    changed_d       = changed_q;
    in_ready_d      = in_ready;
    out_valid_d     = out_valid;
    out_connected_d = out_connected;
    out_visited_d   = out_visited;
    out_passes_d    = out_passes;
    finish          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = SCAN;
          adj_d      = sym;
          visited_d  = NODES'(1);
          ptr_d      = '0;
          pass_d     = PASS_W'(1);
          changed_d  = 1'b0;
          in_ready_d = 1'b0;
        end
      end

      SCAN: begin
        visited_d = nxt;
        if (EARLY_EXIT && (&nxt)) begin
          finish = 1'b1;
        end else if (last_row) begin
          // Another pass only if this one grew the mask
          if (chg) begin
            ptr_d     = '0;
            pass_d    = pass_q + PASS_W'(1);
            changed_d = 1'b0;
          end else begin
            finish = 1'b1;
          end
        end else begin
          ptr_d     = ptr_q + PTR_W'(1);
          changed_d = chg;
        end

        if (finish) begin
          state_d         = DONE;
          out_valid_d     = 1'b1;
          out_connected_d = &nxt;
          out_visited_d   = nxt;
          out_passes_d    = pass_q;
        end
      end

      DONE: begin
        if (out_valid && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_graph_connectivity_sequencer.sv
// Self-checking bench for graph_connectivity_sequencer (NODES=4) with a
// reachability reference model; honours GRAPH_SEQ_EARLY_EXIT_EN when defined.
module tb_graph_connectivity_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = $clog2(N + 1);

  logic            clk;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [N*N-1:0]  in_adj;
  logic            out_valid;
  logic            out_ready;
  logic            out_connected;
  logic [N-1:0]    out_visited;
  logic [PW-1:0]   out_passes;

  int checks;
  int errors;

  graph_connectivity_sequencer #(.NODES(N)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_adj        (in_adj),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_connected (out_connected),
    .out_visited   (out_visited),
    .out_passes    (out_passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: repeated in-order sweeps over undirected neighbour sets
  function automatic void model(input logic [N*N-1:0] adj, output logic conn,
                                output logic [N-1:0] vis, output logic [PW-1:0] pas,
                                output int lat);
    logic [N-1:0] nb [N];
    logic [N-1:0] nv;
    int  passes;
    bit  changed;
    bit  done;
    for (int i = 0; i < int'(N); i++) begin
      nb[i] = '0;
      for (int j = 0; j < int'(N); j++)
        nb[i][j] = adj[i*N + j] | adj[j*N + i];
    end
    vis = N'(1);
    passes = 0;
    done = 1'b0;
    lat = 0;
    while (!done) begin
      passes++;
      changed = 1'b0;
      for (int r = 0; r < int'(N) && !done; r++) begin
        if (vis[r]) begin
          nv = vis | nb[r];
          if (nv != vis) changed = 1'b1;
          vis = nv;
`ifdef GRAPH_SEQ_EARLY_EXIT_EN
          if (&vis) begin
            done = 1'b1;
            lat  = (passes - 1) * int'(N) + r + 2;
          end
`endif
        end
      end
      if (!done && !changed) begin
        done = 1'b1;
        lat  = passes * int'(N) + 1;
      end
    end
    conn = &vis;
    pas  = PW'(passes);
  endfunction

  // Drives one matrix, measures cycles from accept cycle to out_valid, samples result
  task automatic run_txn(input logic [N*N-1:0] adj, input bit hold,
                         output int lat, output logic conn, output logic [N-1:0] vis,
                         output logic [PW-1:0] pas, output bit seen, output bit dropped);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    in_adj    = adj;
    in_valid  = 1'b1;
    out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_adj   = N*N'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    seen    = out_valid;
    conn    = out_connected;
    vis     = out_visited;
    pas     = out_passes;
    dropped = 1'b0;
    if (!hold) begin
      @(posedge clk); #1;
      dropped = !out_valid && in_ready;
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_adj    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_connected !== 1'b0 ||
        out_visited !== '0 || out_passes !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b con=%b vis=%b pas=%0d, want 1 0 0 0000 0",
               in_ready, out_valid, out_connected, out_visited, out_passes);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  // Directed case against spec-derived constants and the model
  task automatic test_directed(input string name, input logic [N*N-1:0] adj,
                               input logic e_conn, input logic [N-1:0] e_vis,
                               input int e_pas, input int e_lat);
    int lat, m_lat;
    logic conn, m_conn;
    logic [N-1:0] vis, m_vis;
    logic [PW-1:0] pas, m_pas;
    bit seen, dropped;
    model(adj, m_conn, m_vis, m_pas, m_lat);
    run_txn(adj, 1'b0, lat, conn, vis, pas, seen, dropped);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: out_valid not seen within %0d cycles", name, lat);
    end
    checks++;
    if (conn !== e_conn || vis !== e_vis || pas !== PW'(e_pas)) begin
      errors++;
      $display("FAIL %s_result: got con=%b vis=%b pas=%0d, want con=%b vis=%b pas=%0d",
               name, conn, vis, pas, e_conn, e_vis, e_pas);
    end
    checks++;
    if (lat != e_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, e_lat);
    end
    checks++;
    if (conn !== m_conn || vis !== m_vis || pas !== m_pas || lat != m_lat) begin
      errors++;
      $display("FAIL %s_model: got con=%b vis=%b pas=%0d lat=%0d, model con=%b vis=%b pas=%0d lat=%0d",
               name, conn, vis, pas, lat, m_conn, m_vis, m_pas, m_lat);
    end
    checks++;
    if (!dropped) begin
      errors++;
      $display("FAIL %s_handshake: got vld=%b rdy=%b after accept, want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_graphs();
    logic [N*N-1:0] chain, rev, full;
    chain = '0; chain[0*N+3] = 1'b1; chain[3*N+2] = 1'b1; chain[2*N+1] = 1'b1;
    rev   = '0; rev[1*N+0]   = 1'b1; rev[2*N+1]   = 1'b1; rev[3*N+2]   = 1'b1;
    full  = '1;
    test_directed("empty", '0, 1'b0, 4'b0001, 1, 5);
`ifdef GRAPH_SEQ_EARLY_EXIT_EN
    test_directed("chain", chain, 1'b1, 4'b1111, 2, 8);
    test_directed("reverse", rev, 1'b1, 4'b1111, 1, 4);
    test_directed("full", full, 1'b1, 4'b1111, 1, 2);
`else
    test_directed("chain", chain, 1'b1, 4'b1111, 3, 13);
    test_directed("reverse", rev, 1'b1, 4'b1111, 2, 9);
    test_directed("full", full, 1'b1, 4'b1111, 2, 9);
`endif
  endtask

  task automatic test_back_to_back();
    int lat, m_lat;
    logic conn, m_conn;
    logic [N-1:0] vis, m_vis;
    logic [PW-1:0] pas, m_pas;
    bit seen, dropped;
    logic [N*N-1:0] adj;
    for (int t = 0; t < 40; t++) begin
      adj = N*N'($urandom);
      if (t % 3 != 0) adj = adj & N*N'($urandom) & N*N'($urandom);
      model(adj, m_conn, m_vis, m_pas, m_lat);
      run_txn(adj, 1'b0, lat, conn, vis, pas, seen, dropped);
      checks++;
      if (!seen || conn !== m_conn || vis !== m_vis || pas !== m_pas || lat != m_lat || !dropped) begin
        errors++;
        $display("FAIL rand_%0d adj=%h: got seen=%b con=%b vis=%b pas=%0d lat=%0d drop=%b, want 1 %b %b %0d %0d 1",
                 t, adj, seen, conn, vis, pas, lat, dropped, m_conn, m_vis, m_pas, m_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, m_lat;
    logic conn, m_conn;
    logic [N-1:0] vis, m_vis;
    logic [PW-1:0] pas, m_pas;
    bit seen, dropped;
    logic [N*N-1:0] adj;
    adj = '0; adj[0*N+2] = 1'b1; adj[2*N+3] = 1'b1;
    model(adj, m_conn, m_vis, m_pas, m_lat);
    run_txn(adj, 1'b1, lat, conn, vis, pas, seen, dropped);
    checks++;
    if (!seen || conn !== m_conn || vis !== m_vis || pas !== m_pas || lat != m_lat) begin
      errors++;
      $display("FAIL bp_result: got seen=%b con=%b vis=%b pas=%0d lat=%0d, want 1 %b %b %0d %0d",
               seen, conn, vis, pas, lat, m_conn, m_vis, m_pas, m_lat);
    end
    in_adj   = '1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_connected !== m_conn ||
          out_visited !== m_vis || out_passes !== m_pas) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b con=%b vis=%b pas=%0d, want 1 0 %b %b %0d",
                 c, out_valid, in_ready, out_connected, out_visited, out_passes, m_conn, m_vis, m_pas);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    checks++;
    if (out_connected !== m_conn || out_visited !== m_vis || out_passes !== m_pas) begin
      errors++;
      $display("FAIL bp_retain: got con=%b vis=%b pas=%0d, want %b %b %0d",
               out_connected, out_visited, out_passes, m_conn, m_vis, m_pas);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, m_lat;
    logic conn, m_conn;
    logic [N-1:0] vis, m_vis;
    logic [PW-1:0] pas, m_pas;
    bit seen, dropped;
    bit spurious;
    logic [N*N-1:0] adj;
    adj = '0; adj[0*N+3] = 1'b1; adj[3*N+2] = 1'b1; adj[2*N+1] = 1'b1;
    in_adj   = adj;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_connected !== 1'b0 ||
        out_visited !== '0 || out_passes !== '0) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b con=%b vis=%b pas=%0d, want 1 0 0 0000 0",
               in_ready, out_valid, out_connected, out_visited, out_passes);
    end
    spurious = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL midreset_abort: got activity after reset, want idle with no result");
    end
    adj = '0; adj[1*N+0] = 1'b1; adj[1*N+3] = 1'b1;
    model(adj, m_conn, m_vis, m_pas, m_lat);
    run_txn(adj, 1'b0, lat, conn, vis, pas, seen, dropped);
    checks++;
    if (!seen || conn !== m_conn || vis !== m_vis || pas !== m_pas || lat != m_lat || !dropped) begin
      errors++;
      $display("FAIL midreset_next: got seen=%b con=%b vis=%b pas=%0d lat=%0d drop=%b, want 1 %b %b %0d %0d 1",
               seen, conn, vis, pas, lat, dropped, m_conn, m_vis, m_pas, m_lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_graphs();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
